wb_dma_copier: RTL and testbench

- Wishbone master that copies a block of 32-bit words from a source range to a destination range, for example a flash image into SDRAM at boot, without involving the CPU.
- Connects to a free master port of the Wishbone interconnect (m2..m7) and issues classic single read and write cycles.
- Controlled by a start pulse plus address and count inputs. Reports busy, done and error status; done can drive a CPU interrupt line.

---
 rtl/wb_dma_copier_if.sv | 23 ++
 rtl/wb_dma_copier.sv | 121 ++++++++++++
 tb/tb_wb_dma_copier.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_dma_copier_if.sv
// Wishbone classic bus between the block copier (master) and the interconnect
// port it is attached to (slave side of this interface).
interface wb_dma_copier_if;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_ack_i;
   logic        wbm_err_i;

   modport master (
      output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      input  wbm_dat_i, wbm_ack_i, wbm_err_i
   );

   modport slave (
      input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
      output wbm_dat_i, wbm_ack_i, wbm_err_i
   );
endinterface

// File: rtl/wb_dma_copier.sv
// Wishbone block copier: word-by-word read/write of a source range into a
// destination range, with a gap cycle after every access for re-arbitration.
module wb_dma_copier #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [CNT_W-1:0] word_cnt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   wb_dma_copier_if.master  wbm
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] RGAP = 3'd2;
   localparam logic [2:0] WR   = 3'd3;
   localparam logic [2:0] WGAP = 3'd4;
   localparam logic [2:0] FIN  = 3'd5;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic [2:0]        state_q, state_d;
   logic [31:0]       src_q, src_d, dst_q, dst_d, dat_q, dat_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic              bus_act, timeout;

   assign bus_act = (state_q == RD) || (state_q == WR);
   // Fires on the last allowed wait cycle so stb stays high exactly TIMEOUT cycles.
   assign timeout = (TIMEOUT != 0) && (32'(wait_q) == 32'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      dat_d   = dat_q;
      cnt_d   = cnt_q;
      wait_d  = '0;
      err_d   = err_q;
      case (state_q)
         IDLE: if (start_i) begin
            src_d   = {src_addr_i[31:2], 2'b00};
            dst_d   = {dst_addr_i[31:2], 2'b00};
            cnt_d   = word_cnt_i;
            err_d   = 1'b0;
            state_d = (word_cnt_i == '0) ? FIN : RD;
         end
         RD: begin
            if (wbm.wbm_err_i) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else if (wbm.wbm_ack_i) begin
               dat_d   = wbm.wbm_dat_i;
               state_d = RGAP;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               wait_d  = wait_q + 1'b1;
            end
         end
         RGAP: state_d = WR;
         WR: begin
            if (wbm.wbm_err_i) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else if (wbm.wbm_ack_i) begin
               src_d   = src_q + 32'd4;
               dst_d   = dst_q + 32'd4;
               cnt_d   = cnt_q - 1'b1;
               state_d = WGAP;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else begin
               wait_d  = wait_q + 1'b1;
            end
         end
         WGAP: state_d = (cnt_q != '0) ? RD : FIN;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         dat_q   <= '0;
         cnt_q   <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         dat_q   <= dat_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   // Bus controls decode straight from the state register, so reset drops them at once.
   assign wbm.wbm_cyc_o = bus_act;
   assign wbm.wbm_stb_o = bus_act;
   assign wbm.wbm_we_o  = (state_q == WR);
   assign wbm.wbm_sel_o = bus_act ? 4'hF : 4'h0;
   assign wbm.wbm_adr_o = (state_q == WR) ? dst_q : src_q;
   assign wbm.wbm_dat_o = dat_q;

   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == FIN);
   assign err_o  = err_q;
endmodule

// File: tb/tb_wb_dma_copier.sv
// Directed bench for wb_dma_copier: memory slave with wait/err/no-ack knobs and
// a queue scoreboard of expected read addresses and write address/data pairs.
module tb_wb_dma_copier;
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        start_i = 1'b0;
   logic [31:0] src_addr_i = '0, dst_addr_i = '0;
   logic [15:0] word_cnt_i = '0;
   logic        busy_o, done_o, err_o;

   wb_dma_copier_if bus();

   wb_dma_copier #(.CNT_W(16), .TIMEOUT(8)) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .start_i    (start_i),
      .src_addr_i (src_addr_i),
      .dst_addr_i (dst_addr_i),
      .word_cnt_i (word_cnt_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .wbm        (bus)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0, errors = 0, done_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory slave: word index from adr[9:2]; ack after `waits` stb cycles.
   logic [31:0] mem [0:255];
   int   waits = 0, wcnt = 0, wr_seen = 0, err_at = -1;
   bit   noack = 1'b0;
   logic ack_c, err_c;
   assign ack_c = bus.wbm_stb_o && !noack && (wcnt == waits);
   assign err_c = bus.wbm_stb_o && bus.wbm_we_o && (wr_seen == err_at);
   assign bus.wbm_ack_i = ack_c;
   assign bus.wbm_err_i = err_c;
   assign bus.wbm_dat_i = mem[bus.wbm_adr_o[9:2]];

   always @(posedge wb_clk_i) begin
      if (bus.wbm_stb_o && bus.wbm_we_o && ack_c && !err_c) begin
         mem[bus.wbm_adr_o[9:2]] = bus.wbm_dat_o;
         wr_seen <= wr_seen + 1;
      end
      if (bus.wbm_stb_o && !ack_c && !err_c) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end

   // Bus monitor and scoreboard.
   logic [31:0] exp_rd_q[$];
   logic [63:0] exp_wr_q[$];
   logic [63:0] mon_e;
   logic        prev_stb = 1'b0, prev_end = 1'b0, prev_we = 1'b0;
   logic [31:0] prev_adr = '0, prev_dat = '0;

   always @(negedge wb_clk_i) begin
      if (wb_rst_i) begin
         prev_stb = 1'b0;
         prev_end = 1'b0;
      end else begin
         if (prev_end) chk("gap_cyc_low", bus.wbm_cyc_o, 0);
         if (bus.wbm_stb_o) begin
            chk("sel", bus.wbm_sel_o, 4'hF);
            if (prev_stb && !prev_end) begin
               chk("hold_adr", bus.wbm_adr_o, prev_adr);
               chk("hold_we", bus.wbm_we_o, prev_we);
               if (prev_we) chk("hold_dat", bus.wbm_dat_o, prev_dat);
            end
            if (ack_c && !err_c) begin
               if (bus.wbm_we_o) begin
                  chk("wr_pending", exp_wr_q.size() != 0, 1);
                  if (exp_wr_q.size() != 0) begin
                     mon_e = exp_wr_q.pop_front();
                     chk("wr_adr", bus.wbm_adr_o, mon_e[63:32]);
                     chk("wr_dat", bus.wbm_dat_o, mon_e[31:0]);
                  end
               end else begin
                  chk("rd_pending", exp_rd_q.size() != 0, 1);
                  if (exp_rd_q.size() != 0) chk("rd_adr", bus.wbm_adr_o, exp_rd_q.pop_front());
               end
            end
         end
         if (done_o) done_cnt++;
         prev_stb = bus.wbm_stb_o;
         prev_end = bus.wbm_stb_o && (ack_c || err_c);
         prev_we  = bus.wbm_we_o;
         prev_adr = bus.wbm_adr_o;
         prev_dat = bus.wbm_dat_o;
      end
   end

   task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] c);
      @(negedge wb_clk_i);
      src_addr_i = s;
      dst_addr_i = d;
      word_cnt_i = c;
      start_i    = 1'b1;
      done_cnt   = 0;
      @(negedge wb_clk_i);
      start_i    = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!done_o && n < max) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("done_seen", done_o, 1);
   endtask

   task automatic end_job(input string tag);
      chk({tag, "_busy_in_fin"}, busy_o, 1);
      @(negedge wb_clk_i);
      chk({tag, "_done_one_cycle"}, done_o, 0);
      chk({tag, "_busy_clear"}, busy_o, 0);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_rd_q_empty"}, exp_rd_q.size(), 0);
      chk({tag, "_wr_q_empty"}, exp_wr_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      logic [31:0] w;
      wb_rst_i = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      #7;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_cyc", bus.wbm_cyc_o, 0);
      chk("rst_stb", bus.wbm_stb_o, 0);
      chk("rst_we", bus.wbm_we_o, 0);
      chk("rst_sel", bus.wbm_sel_o, 0);
      chk("rst_adr", bus.wbm_adr_o, 0);
      chk("rst_dat", bus.wbm_dat_o, 0);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      // 4-word copy, zero waits
      for (int i = 0; i < 4; i++) begin
         w = 32'h1111_1111 * 32'(i + 1);
         mem[i] = w;
         exp_rd_q.push_back(32'h3000_0000 + 32'(4 * i));
         exp_wr_q.push_back({32'h0000_0100 + 32'(4 * i), w});
      end
      start_job(32'h3000_0000, 32'h0000_0100, 16'd4);
      chk("t1_stb_2nd_edge", bus.wbm_stb_o, 1);
      chk("t1_busy", busy_o, 1);
      wait_done(100, n);
      chk("t1_cycles", n, 16);
      chk("t1_err", err_o, 0);
      end_job("t1");
      for (int i = 0; i < 4; i++) chk("t1_mem", mem[64 + i], 32'h1111_1111 * 32'(i + 1));

      // 3 wait states per access, 2 words, 10 cycles per word
      waits = 3;
      for (int i = 0; i < 2; i++) begin
         mem[32 + i] = 32'hCAFE_0000 + 32'(i);
         exp_rd_q.push_back(32'h2000_0080 + 32'(4 * i));
         exp_wr_q.push_back({32'h4000_0200 + 32'(4 * i), 32'hCAFE_0000 + 32'(i)});
      end
      start_job(32'h2000_0083, 32'h4000_0202, 16'd2);
      wait_done(100, n);
      chk("t2_cycles", n, 20);
      end_job("t2");
      waits = 0;

      // Zero count: done on the 2nd edge, no bus activity
      start_job(32'h3000_0000, 32'h0000_0100, 16'd0);
      chk("t3_done_2nd_edge", done_o, 1);
      chk("t3_cyc", bus.wbm_cyc_o, 0);
      wait_done(10, n);
      chk("t3_cycles", n, 0);
      end_job("t3");

      // Slave error on the 2nd write of 5
      for (int i = 0; i < 5; i++) mem[16 + i] = 32'hB0B0_0000 + 32'(i);
      mem[193] = 32'hDEAD_BEEF;
      err_at = wr_seen + 1;
      exp_rd_q.push_back(32'h1000_0040);
      exp_rd_q.push_back(32'h1000_0044);
      exp_wr_q.push_back({32'h0000_0300, 32'hB0B0_0000});
      start_job(32'h1000_0040, 32'h0000_0300, 16'd5);
      wait_done(100, n);
      chk("t4_cycles", n, 7);
      chk("t4_err", err_o, 1);
      end_job("t4");
      chk("t4_word1", mem[192], 32'hB0B0_0000);
      chk("t4_word2_untouched", mem[193], 32'hDEAD_BEEF);
      err_at = -1;
      exp_rd_q.push_back(32'h1000_0040);
      exp_wr_q.push_back({32'h0000_03A0, 32'hB0B0_0000});
      start_job(32'h1000_0040, 32'h0000_03A0, 16'd1);
      chk("t4_err_cleared", err_o, 0);
      wait_done(100, n);
      chk("t4b_cycles", n, 4);
      end_job("t4b");

      // Slave never acks: abort after 8 strobe cycles
      noack = 1'b1;
      start_job(32'h0000_0000, 32'h0000_0000, 16'd1);
      wait_done(100, n);
      chk("t5_timeout_cycles", n, 8);
      chk("t5_err", err_o, 1);
      end_job("t5");
      noack = 1'b0;

      // start while busy is ignored
      for (int i = 0; i < 2; i++) begin
         exp_rd_q.push_back(32'h3000_0000 + 32'(4 * i));
         exp_wr_q.push_back({32'h0000_03C0 + 32'(4 * i), mem[i]});
      end
      start_job(32'h3000_0000, 32'h0000_03C0, 16'd2);
      src_addr_i = 32'h5555_0000;
      dst_addr_i = 32'h0000_0000;
      word_cnt_i = 16'd9;
      start_i    = 1'b1;
      @(negedge wb_clk_i);
      start_i    = 1'b0;
      wait_done(100, n);
      chk("t6_cycles", n, 7);
      chk("t6_err", err_o, 0);
      end_job("t6");
      chk("t6_mem0", mem[240], 32'h1111_1111);
      chk("t6_mem1", mem[241], 32'h2222_2222);

      // Source address wraps past 0xFFFF_FFFC
      mem[255] = 32'h7777_0001;
      exp_rd_q.push_back(32'hFFFF_FFFC);
      exp_rd_q.push_back(32'h0000_0000);
      exp_wr_q.push_back({32'h0000_0380, 32'h7777_0001});
      exp_wr_q.push_back({32'h0000_0384, 32'h1111_1111});
      start_job(32'hFFFF_FFFC, 32'h0000_0380, 16'd2);
      wait_done(100, n);
      chk("t7_cycles", n, 8);
      end_job("t7");

      // Reset asserted during a write
      for (int i = 0; i < 3; i++) begin
         exp_rd_q.push_back(32'h3000_0000 + 32'(4 * i));
         exp_wr_q.push_back({32'h0000_03E0 + 32'(4 * i), mem[i]});
      end
      start_job(32'h3000_0000, 32'h0000_03E0, 16'd3);
      n = 0;
      while (!(bus.wbm_stb_o && bus.wbm_we_o) && n < 20) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("t8_reached_wr", bus.wbm_stb_o && bus.wbm_we_o, 1);
      #2 wb_rst_i = 1'b1;
      #1;
      chk("t8_cyc", bus.wbm_cyc_o, 0);
      chk("t8_stb", bus.wbm_stb_o, 0);
      chk("t8_we", bus.wbm_we_o, 0);
      chk("t8_sel", bus.wbm_sel_o, 0);
      chk("t8_adr", bus.wbm_adr_o, 0);
      chk("t8_dat", bus.wbm_dat_o, 0);
      chk("t8_busy", busy_o, 0);
      chk("t8_done", done_o, 0);
      exp_rd_q.delete();
      exp_wr_q.delete();
      repeat (2) @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      repeat (4) @(negedge wb_clk_i);
      chk("t8_no_done", done_cnt, 0);
      chk("t8_idle", busy_o, 0);
      chk("t8_err", err_o, 0);
      chk("t8_no_write", mem[248], 32'hA5A5_00F8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
